// File: rtl/data_mem.sv
// Byte-addressable 32-bit data memory with a fixed-latency request/response pipeline.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of being force-aligned.
module data_mem #(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hx)};

    logic                  w_accept;
    logic                  w_bad_size;
    logic                  w_err;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_idx;

    assign req_ready  = ~rst;
    assign w_accept   = req_valid & ~rst;
    assign w_idx      = req_addr[ADDR_WIDTH+1:2];
    assign w_bad_size = (req_size == 2'b11);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_err      = w_bad_size | w_misalign;
    assign w_lane     = req_addr[1:0];
`else
    // Misaligned halves/words silently drop the low address bits.
    assign w_err  = w_bad_size;
    assign w_lane = (req_size == 2'b01) ? {req_addr[1], 1'b0} :
                    (req_size == 2'b10) ? 2'b00 : req_addr[1:0];
`endif

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b10: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_wr_en = w_accept & req_we & ~w_err;

    logic [31:0] r_word1;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
        if (w_accept) r_word1 <= r_mem[w_idx];
    end

    logic       r_v1;
    logic       r_we1;
    logic       r_err1;
    logic       r_uns1;
    logic [1:0] r_size1;
    logic [1:0] r_lane1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_we1   <= 1'b0;
            r_err1  <= 1'b0;
            r_uns1  <= 1'b0;
            r_size1 <= 2'b00;
            r_lane1 <= 2'b00;
        end else begin
            r_v1 <= w_accept;
            if (w_accept) begin
                r_we1   <= req_we;
                r_err1  <= w_err;
                r_uns1  <= req_unsigned;
                r_size1 <= req_size;
                r_lane1 <= w_lane;
            end
        end
    end

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_rdata1;

    always_comb begin
        w_byte = r_word1[7:0];
        case (r_lane1)
            2'b00: w_byte = r_word1[7:0];
            2'b01: w_byte = r_word1[15:8];
            2'b10: w_byte = r_word1[23:16];
            default: w_byte = r_word1[31:24];
        endcase
        w_half = r_lane1[1] ? r_word1[31:16] : r_word1[15:0];
        case (r_size1)
            2'b00:   w_load = r_uns1 ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'b01:   w_load = r_uns1 ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load = r_word1;
        endcase
        // Stores, errors and idle cycles all present zero data.
        w_rdata1 = (r_v1 && !r_we1 && !r_err1) ? w_load : 32'h0;
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        r_v2;
            logic        r_err2;
            logic [31:0] r_rdata2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v2     <= 1'b0;
                    r_err2   <= 1'b0;
                    r_rdata2 <= 32'h0;
                end else begin
                    r_v2     <= r_v1;
                    r_err2   <= r_v1 & r_err1;
                    r_rdata2 <= w_rdata1;
                end
            end

            assign rsp_valid = r_v2;
            assign rsp_err   = r_err2;
            assign rsp_rdata = r_rdata2;
        end else begin : g_lat1
            assign rsp_valid = r_v1;
            assign rsp_err   = r_v1 & r_err1;
            assign rsp_rdata = w_rdata1;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: loads/stores, lanes, errors, back-to-back and reset.
module tb_data_mem;
    localparam int AW  = 10;
    localparam int LAT = 1;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_we;
    logic [AW+1:0] req_addr;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_wdata;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    data_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .INIT_ZERO(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic drive(input logic we, input logic [AW+1:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
    endtask

    // Single request, then wait out the latency and check the response.
    task automatic do_req(input string tag, input logic we, input logic [AW+1:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        drive(we, addr, size, uns, wd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        check_val({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        check_val({tag, ".data"}, rsp_rdata, exp_d);
        check_val({tag, ".err"}, 32'(rsp_err), 32'(exp_e));
    endtask

    typedef struct {
        logic          we;
        logic [AW+1:0] addr;
        logic [1:0]    size;
        logic          uns;
        logic [31:0]   wd;
        logic [31:0]   exp_d;
    } vec_t;

    vec_t b2b [4];
    int   pulses;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 2'b10, 1'b0, 32'h0);
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.valid", 32'(rsp_valid), 32'd0);
        check_val("rst.data", rsp_rdata, 32'h0);
        check_val("rst.err", 32'(rsp_err), 32'd0);
        check_val("rst.ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("ready", 32'(req_ready), 32'd1);

        do_req("st_w_010", 1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("ld_w_010", 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("st_b_013", 1'b1, 12'h013, 2'b00, 1'b0, 32'h00000080, 32'h0, 1'b0);
        do_req("ld_bs_013", 1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("ld_bu_013", 1'b0, 12'h013, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0);
        do_req("ld_w_010b", 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);

        do_req("st_w_020", 1'b1, 12'h020, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
        do_req("st_h_022", 1'b1, 12'h022, 2'b01, 1'b0, 32'h00001234, 32'h0, 1'b0);
        do_req("ld_hs_022", 1'b0, 12'h022, 2'b01, 1'b0, 32'h0, 32'h00001234, 1'b0);
        do_req("ld_hu_020", 1'b0, 12'h020, 2'b01, 1'b1, 32'h0, 32'h0000F00D, 1'b0);
        do_req("ld_hs_020", 1'b0, 12'h020, 2'b01, 1'b0, 32'h0, 32'hFFFFF00D, 1'b0);
        do_req("ld_w_020", 1'b0, 12'h020, 2'b10, 1'b0, 32'h0, 32'h1234F00D, 1'b0);

        do_req("ld_w_011", 1'b0, 12'h011, 2'b10, 1'b0, 32'h0,
               TRAP ? 32'h0 : 32'h80ADBEEF, TRAP);
        do_req("st_h_021", 1'b1, 12'h021, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, TRAP);
        do_req("ld_w_020b", 1'b0, 12'h020, 2'b10, 1'b0, 32'h0,
               TRAP ? 32'h1234F00D : 32'h1234FFFF, 1'b0);

        do_req("st_w_030", 1'b1, 12'h030, 2'b10, 1'b0, 32'h11223344, 32'h0, 1'b0);
        do_req("st_rsv_030", 1'b1, 12'h030, 2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
        do_req("ld_w_030", 1'b0, 12'h030, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0);
        do_req("ld_bu_031", 1'b0, 12'h031, 2'b00, 1'b1, 32'h0, 32'h00000033, 1'b0);
        do_req("ld_bs_032", 1'b0, 12'h032, 2'b00, 1'b0, 32'h0, 32'h00000022, 1'b0);
        do_req("st_w_ffc", 1'b1, 12'hFFC, 2'b10, 1'b0, 32'hA5A5A5A5, 32'h0, 1'b0);
        do_req("ld_w_ffc", 1'b0, 12'hFFC, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Back-to-back, including a load of a word stored the cycle before.
        b2b[0] = '{1'b1, 12'h040, 2'b10, 1'b0, 32'h55667788, 32'h0};
        b2b[1] = '{1'b0, 12'h040, 2'b10, 1'b0, 32'h0, 32'h55667788};
        b2b[2] = '{1'b0, 12'h013, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80};
        b2b[3] = '{1'b0, 12'h030, 2'b10, 1'b0, 32'h0, 32'h11223344};
        for (int i = 0; i < 4 + LAT - 1; i++) begin
            @(negedge clk);
            if (i < 4) drive(b2b[i].we, b2b[i].addr, b2b[i].size, b2b[i].uns, b2b[i].wd);
            else req_valid = 1'b0;
            @(posedge clk);
            #1;
            if (i >= LAT - 1) begin
                check_val($sformatf("b2b%0d.valid", i - (LAT - 1)), 32'(rsp_valid), 32'd1);
                check_val($sformatf("b2b%0d.data", i - (LAT - 1)), rsp_rdata,
                          b2b[i - (LAT - 1)].exp_d);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;

        // Reset lands the cycle after the 2nd of four back-to-back requests.
        pulses = 0;
        @(negedge clk);
        drive(1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        pulses += int'(rsp_valid);
        @(negedge clk);
        drive(1'b0, 12'h020, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        pulses += int'(rsp_valid);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 12'h030, 2'b10, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check_val("rstmid.valid", 32'(rsp_valid), 32'd0);
        check_val("rstmid.data", rsp_rdata, 32'h0);
        check_val("rstmid.err", 32'(rsp_err), 32'd0);
        check_val("rstmid.ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        drive(1'b1, 12'h010, 2'b10, 1'b0, 32'hBADBAD00);
        @(posedge clk);
        #1;
        check_val("rstmid.valid2", 32'(rsp_valid), 32'd0);
        check_val("rstmid.pulses", 32'(pulses), 32'(3 - LAT));
        @(negedge clk);
        rst = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_val("postrst.valid", 32'(rsp_valid), 32'd0);
        do_req("ld_w_010c", 1'b0, 12'h010, 2'b10, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address bits (2^ADDR_WIDTH 32-bit words).
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2, cycles from request accept to response.
REQ-003 SHALL have parameter INIT_ZERO, default 1, zero all words at elaboration when 1.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_WIDTH+2  byte address.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-010 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 req_ready  output  1  request accepted when req_valid & req_ready.
REQ-013 rsp_valid  output  1  one-cycle pulse per accepted request, loads and stores.
REQ-014 rsp_rdata  output  32  load result; 0 for stores and errored requests.
REQ-015 rsp_err  output  1  qualifies rsp_valid; access misaligned or req_size = 11.

Function
REQ-016 req_ready SHALL be 0 while rst is high and 1 otherwise; no backpressure, one request per cycle.
REQ-017 Word index SHALL be req_addr[ADDR_WIDTH+1:2]; byte lane SHALL be req_addr[1:0].
REQ-018 Stores SHALL write only the addressed lanes via byte enables (byte: 1 lane, half: lanes 0-1 or 2-3, word: all 4) at the accepting edge; other lanes SHALL be unchanged.
REQ-019 Loads SHALL read the word synchronously, extract the addressed lane(s), and sign- or zero-extend to 32 bits per req_unsigned.
REQ-020 rsp_valid/rsp_rdata/rsp_err SHALL appear exactly READ_LATENCY cycles after acceptance, in request order, through a READ_LATENCY-deep valid/size/lane/unsigned pipeline.
REQ-021 A load accepted the cycle after a store to the same word SHALL return post-store data.
REQ-022 Back-to-back requests every cycle SHALL produce back-to-back responses with no bubbles.
REQ-023 req_size = 11 SHALL produce rsp_err = 1 and SHALL NOT write memory.
REQ-024 Address wraps modulo 2^(ADDR_WIDTH+2); no out-of-range condition exists.

Reset
REQ-025 On rst, all response-pipeline valid stages SHALL clear; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0 the cycle after rst asserts.
REQ-026 Requests in flight when rst asserts SHALL be dropped with no response; memory contents SHALL NOT be cleared by rst.
REQ-027 A store presented while rst is high SHALL NOT write memory.

Configuration
REQ-028 Macro DATA_MEM_MISALIGN_TRAP_EN defined: half with req_addr[0] = 1 or word with req_addr[1:0] != 00 SHALL give rsp_err = 1, rsp_rdata = 0, and no memory write.
REQ-029 Macro DATA_MEM_MISALIGN_TRAP_EN undefined: misaligned low address bits SHALL be forced to alignment (half clears bit 0, word clears bits 1:0), access completes, rsp_err reflects only req_size = 11.

Verification
REQ-030 Store word 0xDEADBEEF @0x010, load word @0x010 -> rsp_rdata 0xDEADBEEF, rsp_err 0, READ_LATENCY cycles after accept.
REQ-031 Then store byte 0x80 @0x013; load byte signed @0x013 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word @0x010 -> 0x80ADBEEF.
REQ-032 Store half 0x1234 @0x022, load half signed @0x022 -> 0x00001234; lanes 0-1 of word 0x020 unchanged.
REQ-033 Load word @0x011: with DATA_MEM_MISALIGN_TRAP_EN -> rsp_err 1, rsp_rdata 0; without -> rsp_err 0, data of 0x010.
REQ-034 Four back-to-back loads, rst high on the cycle after the 2nd accept -> at most responses for requests accepted READ_LATENCY or more cycles before rst, none after; req_ready 0 during rst.
REQ-035 Request with req_size 11 as store of 0xFFFFFFFF @0x030 -> rsp_err 1; subsequent load word @0x030 returns prior contents.
